// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 key event decoder.
// KEY_AUTOREPEAT_EN in the top enables the auto-repeat path.
package ps2_key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam int         KEY_CODE_W = 9;

   // Channel code layout: bit 8 is the E0-extended flag, bits 7:0 the make code.
   function automatic logic [KEY_CODE_W-1:0] key_code(input logic ext, input logic [7:0] b);
      return {ext, b};
   endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// Auto-repeat interval timer: first pulse DELAY cycles after start, then every PERIOD.
// Only instantiated when KEY_AUTOREPEAT_EN is defined.
module ps2_repeat_timer #(
   parameter int DELAY  = 25_000_000,
   parameter int PERIOD = 5_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic stop_i,
   output logic repeat_o
);

   localparam int MAX_T = (DELAY > PERIOD) ? DELAY : PERIOD;
   localparam int CNT_W = $clog2(MAX_T + 1);

   logic             active_q, active_d;
   logic             first_q, first_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] limit;

   // start and stop both veto the pulse due in the same cycle
   assign limit    = first_q ? CNT_W'(DELAY - 1) : CNT_W'(PERIOD - 1);
   assign repeat_o = active_q && !start_i && !stop_i && (cnt_q == limit);

   always_comb begin
      active_d = active_q;
      first_d  = first_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         active_d = 1'b1;
         first_d  = 1'b1;
         cnt_d    = '0;
      end else if (stop_i) begin
         active_d = 1'b0;
         cnt_d    = '0;
      end else if (repeat_o) begin
         first_d  = 1'b0;
         cnt_d    = '0;
      end else if (active_q) begin
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         first_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         first_q  <= first_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code byte stream to per-channel press/release/held signals.
// Define KEY_AUTOREPEAT_EN to add typematic-style repeat pulses on the newest held key.
module ps2_key_event_decoder
   import ps2_key_pkg::*;
#(
   parameter int NUM_KEYS       = 5,
   parameter int PREFIX_TIMEOUT = 2_500_000,
   parameter int REPEAT_DELAY   = 25_000_000,
   parameter int REPEAT_PERIOD  = 5_000_000
) (
   input  logic                           CLK_50M,
   input  logic                           RST,
   input  logic [7:0]                     ps2_byte,
   input  logic                           ps2_state,
   input  logic [NUM_KEYS*KEY_CODE_W-1:0] key_codes,
   input  logic                           clear_keys,
   output logic [NUM_KEYS-1:0]            key_press,
   output logic [NUM_KEYS-1:0]            key_release,
   output logic [NUM_KEYS-1:0]            key_held,
   output logic                           any_press,
   output ps2_state_e                     dbg_state
);

   localparam int TMO_W = $clog2(PREFIX_TIMEOUT + 1);

   ps2_state_e          state_q, state_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                tmo_hit;
   logic                ev_valid, ev_ext, ev_brk;
   logic [KEY_CODE_W-1:0] ev_code;
   logic [NUM_KEYS-1:0] match, make_hit, brk_hit, rpt_mask;
   logic [NUM_KEYS-1:0] held_q, held_d, press_q, press_d, release_q, release_d;

   // ps2_state is a single-cycle strobe; there is no back-pressure, every strobed byte is consumed.
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   assign tmo_hit = (state_q != ST_IDLE) && !ps2_state && (tmo_q == TMO_W'(PREFIX_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      if (clear_keys) begin
         state_d = ST_IDLE;
      end else if (ps2_state) begin
         if (ps2_byte == PS2_EXT) begin
            state_d = ST_EXT;
         end else if (ps2_byte == PS2_BRK) begin
            case (state_q)
               ST_IDLE, ST_BRK:    state_d = ST_BRK;
               ST_EXT, ST_EXT_BRK: state_d = ST_EXT_BRK;
               default:            state_d = ST_IDLE;
            endcase
         end else begin
            state_d = ST_IDLE;
         end
      end else if (tmo_hit) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      ev_valid = ps2_state && !clear_keys && (ps2_byte != PS2_EXT) && (ps2_byte != PS2_BRK);
      ev_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
      ev_brk   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      ev_code  = key_code(ev_ext, ps2_byte);
      match    = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         match[i] = ev_valid && (key_codes[i*KEY_CODE_W +: KEY_CODE_W] == ev_code);
      end
      make_hit = match & ~held_q & {NUM_KEYS{~ev_brk}};
      brk_hit  = match &  held_q & {NUM_KEYS{ev_brk}};
   end

   always_comb begin
      tmo_d = tmo_q + TMO_W'(1);
      if (clear_keys || ps2_state || (state_q == ST_IDLE) || tmo_hit) tmo_d = '0;
   end

   always_comb begin
      held_d    = (held_q | make_hit) & ~brk_hit;
      press_d   = make_hit | rpt_mask;
      release_d = brk_hit;
      if (clear_keys) begin
         held_d    = '0;
         press_d   = '0;
         release_d = '0;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int CH_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   logic [CH_W-1:0] rpt_ch_q, rpt_ch_d;
   logic            rpt_start, rpt_stop, rpt_fire;

   // On simultaneous presses the highest-numbered channel becomes the repeat target.
   always_comb begin
      rpt_ch_d = rpt_ch_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (make_hit[i]) rpt_ch_d = CH_W'(i);
      end
      rpt_start = |make_hit;
      rpt_stop  = clear_keys || brk_hit[rpt_ch_q];
      rpt_mask  = '0;
      if (rpt_fire) rpt_mask[rpt_ch_q] = 1'b1;
   end

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) rpt_ch_q <= '0;
      else     rpt_ch_q <= rpt_ch_d;
   end

   ps2_repeat_timer #(
      .DELAY  (REPEAT_DELAY),
      .PERIOD (REPEAT_PERIOD)
   ) u_repeat_timer (
      .clk_i    (CLK_50M),
      .rst_i    (RST),
      .start_i  (rpt_start),
      .stop_i   (rpt_stop),
      .repeat_o (rpt_fire)
   );
`else
   assign rpt_mask = '0;
`endif

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         tmo_q     <= '0;
         held_q    <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         tmo_q     <= tmo_d;
         held_q    <= held_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_held    = held_q;
   assign any_press   = |press_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench for ps2_key_event_decoder: directed scenarios plus random byte traffic
// checked every cycle against a rule-level model. Define KEY_AUTOREPEAT_EN to cover repeat timing.
module tb_ps2_key_event_decoder;
  import ps2_key_pkg::*;

  localparam int NK = 5;
  localparam int PT = 50;
  localparam int RD = 100;
  localparam int RP = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]      ps2_byte = 8'h00;
  logic            ps2_state = 1'b0;
  logic [NK*9-1:0] key_codes = '0;
  logic            clear_keys = 1'b0;
  logic [NK-1:0]   key_press, key_release, key_held;
  logic            any_press;
  ps2_state_e      dbg_state;

  ps2_key_event_decoder #(
    .NUM_KEYS       (NK),
    .PREFIX_TIMEOUT (PT),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK_50M     (clk),
    .RST         (rst),
    .ps2_byte    (ps2_byte),
    .ps2_state   (ps2_state),
    .key_codes   (key_codes),
    .clear_keys  (clear_keys),
    .key_press   (key_press),
    .key_release (key_release),
    .key_held    (key_held),
    .any_press   (any_press),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  int p1_cnt = 0;
  int r1_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NK-1:0] m_held = '0;
  bit m_ext = 0, m_brk = 0;
  int m_idle = 0;
  int m_rpt_ch = -1;
  int m_rpt_t0 = 0;

  task automatic model_reset();
    m_held = '0; m_ext = 0; m_brk = 0; m_idle = 0; m_rpt_ch = -1;
  endtask

  task automatic model_cycle(input logic s, input logic [7:0] b, input logic c,
                             output logic [NK-1:0] ep, output logic [NK-1:0] er);
    logic [8:0] code;
    ep = '0;
    er = '0;
    if (c) begin
      model_reset();
    end else if (s) begin
      m_idle = 0;
      if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        code = {m_ext, b};
        for (int i = 0; i < NK; i++) begin
          if (key_codes[i*9 +: 9] == code) begin
            if (!m_brk && !m_held[i]) begin
              ep[i] = 1'b1; m_held[i] = 1'b1; m_rpt_ch = i; m_rpt_t0 = cyc;
            end else if (m_brk && m_held[i]) begin
              er[i] = 1'b1; m_held[i] = 1'b0;
              if (m_rpt_ch == i) m_rpt_ch = -1;
            end
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end else begin
      m_idle++;
      if (m_idle >= PT) begin m_ext = 0; m_brk = 0; end
    end
`ifdef KEY_AUTOREPEAT_EN
    if (m_rpt_ch >= 0 && (cyc - m_rpt_t0) >= RD && ((cyc - m_rpt_t0 - RD) % RP) == 0)
      ep[m_rpt_ch] = 1'b1;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [7:0] b, input logic c, input string tag);
    logic [NK-1:0] ep, er;
    ps2_state = s; ps2_byte = b; clear_keys = c;
    @(posedge clk);
    @(negedge clk);
    model_cycle(s, b, c, ep, er);
    check_val({tag, "_press"},   32'(key_press),   32'(ep));
    check_val({tag, "_release"}, 32'(key_release), 32'(er));
    check_val({tag, "_held"},    32'(key_held),    32'(m_held));
    check_val({tag, "_any"},     32'(any_press),   32'(|ep));
    if (key_press[1]) begin p1_cnt++; act_q.push_back(32'(cyc)); end
    if (key_release[1]) r1_cnt++;
    ps2_state = 1'b0; clear_keys = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0, "byte");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, "idle");
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2_state = 1'b0; clear_keys = 1'b0;
    #1;
    check_val("rst_press",   32'(key_press),   0);
    check_val("rst_release", 32'(key_release), 0);
    check_val("rst_held",    32'(key_held),    0);
    check_val("rst_any",     32'(any_press),   0);
    check_val("rst_state",   32'(dbg_state),   32'(ST_IDLE));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_kc(input int ch, input logic [8:0] code);
    key_codes[ch*9 +: 9] = code;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] byte_pool[10] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h12, 8'h5A, 8'hE1, 8'hAA, 8'h16};
  logic [8:0] code_pool[8]  = '{9'h16B, 9'h074, 9'h01C, 9'h112, 9'h05A, 9'h06B, 9'h174, 9'h11C};

  initial begin
    int r;
    int t0;
    @(negedge clk);
    do_reset();

    set_kc(0, 9'h16B); set_kc(1, 9'h074); set_kc(2, 9'h01C); set_kc(3, 9'h112); set_kc(4, 9'h05A);

    // extended make on channel 0
    send(8'hE0);
    check_val("ext_state", 32'(dbg_state), 32'(ST_EXT));
    send(8'h6B);
    check_val("ext_make_press0", 32'(key_press[0]), 1);
    check_val("ext_make_held0",  32'(key_held[0]), 1);
    idle(3);

    // extended break, then plain 6B that must not match the extended channel
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_val("ext_brk_release0", 32'(key_release[0]), 1);
    check_val("ext_brk_held0",    32'(key_held[0]), 0);
    idle(2);
    send(8'h6B);
    check_val("plain_6b_no_act", 32'({key_press, key_release}), 0);
    check_val("plain_6b_idle",   32'(dbg_state), 32'(ST_IDLE));
    idle(2);

    // typematic makes give a single press, then one release
    p1_cnt = 0; r1_cnt = 0;
    for (int i = 0; i < 5; i++) begin send(8'h74); idle(1); end
    check_val("typematic_one_press", 32'(p1_cnt), 1);
    send(8'hF0); send(8'h74);
    check_val("typematic_one_release", 32'(r1_cnt), 1);
    check_val("typematic_held1", 32'(key_held[1]), 0);
    idle(2);

    // prefix timeout: exactly PT idle cycles drops the E0, PT-1 does not
    set_kc(2, 9'h06B);
    send(8'hE0); idle(PT); send(8'h6B);
    check_val("tmo_plain_press", 32'(key_press), 32'(5'b00100));
    send(8'hF0); send(8'h6B);
    send(8'hE0); idle(PT - 1); send(8'h6B);
    check_val("tmo_edge_ext_press", 32'(key_press), 32'(5'b00001));
    send(8'hE0); send(8'hF0); send(8'h6B);
    set_kc(2, 9'h01C);
    idle(2);

    // reset between F0 and 74 while channel 1 is held
    send(8'h74);
    check_val("pre_rst_held1", 32'(key_held[1]), 1);
    send(8'hF0);
    do_reset();
    send(8'h74);
    check_val("post_rst_fresh_press", 32'(key_press), 32'(5'b00010));
    idle(2);

    // unmatched codes and clear_keys racing a strobe
    send(8'hE1); send(8'hAA);
    check_val("unmatched_no_act", 32'({key_press, key_release}), 0);
    send(8'h5A);
    drive(1'b1, 8'h1C, 1'b1, "clr");
    check_val("clr_held", 32'(key_held), 0);
    check_val("clr_state", 32'(dbg_state), 32'(ST_IDLE));
    idle(2);

`ifdef KEY_AUTOREPEAT_EN
    // repeat pulses at +RD, +RD+RP, +RD+2RP, none after release
    send(8'h74);
    t0 = cyc;
    act_q.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(t0 + RD + k*RP));
    idle(150);
    check_val("rpt_count", 32'(act_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < 3; k++) begin
      if (k < act_q.size()) check_val("rpt_time", act_q[k], exp_q[k]);
    end
    send(8'hF0); send(8'h74);
    act_q.delete();
    idle(60);
    check_val("rpt_stopped", 32'(act_q.size()), 0);
`endif

    // random traffic against the model
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        send(byte_pool[$urandom_range(0, 9)]);
      end else if (r < 63) begin
        drive($urandom_range(0, 1) == 1, byte_pool[$urandom_range(0, 9)], 1'b1, "rclr");
      end else if (r < 66) begin
        set_kc($urandom_range(0, NK - 1), code_pool[$urandom_range(0, 7)]);
      end else if (r < 70) begin
        idle($urandom_range(PT - 2, PT + 1));
      end else begin
        idle($urandom_range(1, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_key_event_decoder.md
PS2_KEY_EVENT_DECODER -- requirements
Module: ps2_key_event_decoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 5, number of decoded key channels (1..16).
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 2_500_000, cycles allowed between a prefix byte and the next byte.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25_000_000, cycles from press to first auto-repeat.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5_000_000, cycles between subsequent auto-repeats.
REQ-005 SHALL have one clock and an asynchronous active-high reset: CLK_50M input 1, system clock; RST input 1, asynchronous active-high reset.
REQ-006 SHALL have port ps2_byte input 8, received scan-code byte.
REQ-007 SHALL have port ps2_state input 1, one-cycle strobe marking ps2_byte valid.
REQ-008 SHALL have port key_codes input NUM_KEYS*9: per channel, bit 8 is the E0-extended flag and bits 7:0 are the make code.
REQ-009 SHALL have port clear_keys input 1, synchronous clear of all held state.
REQ-010 SHALL have port key_press output NUM_KEYS, one-cycle press pulse per channel.
REQ-011 SHALL have port key_release output NUM_KEYS, one-cycle release pulse per channel.
REQ-012 SHALL have port key_held output NUM_KEYS, level high while a key is down.
REQ-013 SHALL have port any_press output 1, the OR of key_press.

Function
REQ-014 Byte FSM states SHALL be IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); bytes are consumed only when ps2_state=1.
REQ-015 FSM transitions:
- IDLE: E0 -> EXT; F0 -> BRK.
- EXT: F0 -> EXT_BRK.
- Any other byte SHALL complete an event (make or break, extended or not) and return to IDLE.
REQ-016 A byte of E0 in EXT, BRK or EXT_BRK SHALL restart to EXT; a byte of F0 in BRK or EXT_BRK SHALL stay in its state.
REQ-017 Prefix timeout: PREFIX_TIMEOUT cycles in a non-IDLE state without ps2_state SHALL return the FSM to IDLE with no event.
REQ-018 Channel match: a completed event matches a channel when its code and extended flag both equal key_codes for that channel; every matching channel acts.
REQ-019 Make events:
- Make on a channel with key_held=0 SHALL set key_held and pulse key_press one cycle after the completing strobe (latency 1).
- Make with key_held=1 (keyboard typematic) SHALL produce no pulse.
REQ-020 Break events:
- Break with key_held=1 SHALL clear key_held and pulse key_release with latency 1.
- Break with key_held=0 SHALL be ignored.
REQ-021 Events matching no channel (including E1 and AA) SHALL be discarded with no output change.
REQ-022 clear_keys=1 SHALL zero key_held and the FSM next cycle with no release pulses; clear_keys wins over a simultaneous strobe.
REQ-023 Changes to key_codes SHALL take effect on the next completed event; held flags are unaffected.

Reset
REQ-024 RST=1 SHALL asynchronously force FSM=IDLE, all counters=0, and key_press, key_release, key_held, any_press = 0.
REQ-025 Reset mid-sequence (after E0 or F0) SHALL discard the partial sequence; the first byte after reset is decoded from IDLE.

Configuration
REQ-026 With KEY_AUTOREPEAT_EN defined, the most recently pressed held channel SHALL generate extra key_press pulses at REPEAT_DELAY after its press and then every REPEAT_PERIOD.
REQ-027 Auto-repeat SHALL stop on that channel's release, on clear_keys, or on a newer press, which retargets and restarts the delay.
REQ-028 Without KEY_AUTOREPEAT_EN, no repeat logic SHALL exist and key_press SHALL fire only per REQ-019.

Structure
REQ-029 Package ps2_key_pkg SHALL hold:
- the FSM state enum;
- constants PS2_EXT=8'hE0, PS2_BRK=8'hF0 and KEY_CODE_W=9.
REQ-030 Auto-repeat timing SHALL be a sub-module ps2_repeat_timer (start, stop, repeat pulse out), instantiated only under KEY_AUTOREPEAT_EN.

Verification
REQ-031 Bench SHALL cover: key_codes channel0=9'h16B, channel1=9'h074; bytes E0,6B -> key_press[0] pulses once, key_held[0]=1.
REQ-032 Bench SHALL cover: E0,F0,6B after REQ-031 -> key_release[0] pulse, key_held[0]=0; bytes 6B alone -> no channel acts (extended flag mismatch).
REQ-033 Bench SHALL cover: 74 repeated 5 times -> exactly one key_press[1]; then F0,74 -> one key_release[1].
REQ-034 Bench SHALL cover: E0, then PREFIX_TIMEOUT idle cycles, then 6B -> no event; FSM decodes 6B as non-extended.
REQ-035 Bench SHALL cover: RST asserted between F0 and 74 while key_held[1]=1 -> all outputs 0; the following 74 gives a fresh press.
REQ-036 Bench SHALL cover, with KEY_AUTOREPEAT_EN, REPEAT_DELAY=100, REPEAT_PERIOD=20: hold channel1 -> repeat pulses at +100, +120, +140; stop on F0,74.
